aes_round_pipe: RTL and testbench
=================================

AES_ROUND_PIPE -- requirements
Module: aes_round_pipe

Interface
REQ-001 The block SHALL have parameter DECRYPT, default 0, meaning 0 = forward round (encryption), 1 = equivalent-inverse round (decryption).
REQ-002 The block SHALL have parameter MIX_COLUMNS_EN, default 1, meaning 0 = MixColumns stage is a register-only bypass (final round).
REQ-003 The block SHALL have parameter USER_W, default 8, meaning sideband width carried alongside each beat (1..64).
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 s_tdata  input  128  input state; byte n = bits [8n+:8]; byte 4c+r = row r, column c.
REQ-007 s_tvalid / s_tready / s_tlast  input / output / input  1 each  AXI-Stream input handshake and frame end.
REQ-008 s_tuser  input  USER_W  sideband; passed through unchanged.
REQ-009 round_key  input  128  round key, same byte mapping as s_tdata; sampled with the s_t* beat.
REQ-010 m_tdata  output  128  round result.
REQ-011 m_tvalid / m_tready / m_tlast  output / input / output  1 each  AXI-Stream output handshake and frame end.
REQ-012 m_tuser  output  USER_W  sideband of the output beat.

Function
REQ-013 The block SHALL be a 4-stage elastic pipeline: S1 SubBytes, S2 ShiftRows, S3 MixColumns, S4 AddRoundKey.
REQ-014 With DECRYPT=1, the stages SHALL apply InvSubBytes, InvShiftRows and InvMixColumns; the caller supplies a key already InvMixColumns-transformed.
REQ-015 ShiftRows SHALL compute out[r][c] = in[r][(c+r) mod 4]; InvShiftRows SHALL compute out[r][c] = in[r][(c-r) mod 4].
REQ-016 MixColumns SHALL use the FIPS-197 matrix {02,03,01,01} and InvMixColumns {0e,0b,0d,09}, in GF(2^8) with polynomial 0x11b.
REQ-017 round_key, tlast and tuser SHALL each travel in a per-stage register with their beat; a key change between beats SHALL NOT affect beats already accepted.
REQ-018 Each stage k SHALL hold a valid flag v_k and SHALL load when !v_k or when stage k is draining (stage k+1 loads, or k=4 and m_tready=1).
REQ-019 s_tready SHALL equal (!v_1 | stage 1 draining) and SHALL be combinational from m_tready through the stage chain; no skid buffer.
REQ-020 Latency SHALL be exactly 4 cycles from the s_tvalid&s_tready edge to m_tvalid=1 when m_tready stays 1.
REQ-021 Throughput SHALL be 1 beat per cycle when m_tready stays 1.
REQ-022 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tuser SHALL stay stable, and m_tvalid SHALL stay 1.
REQ-023 Under any m_tready pattern, beats SHALL never be dropped, duplicated or reordered; the maximum number of beats in flight is 4.
REQ-024 Bubbles SHALL collapse: a stage with v_k=0 accepts upstream data even while downstream stages are stalled.
REQ-025 A stage load and a stage drain in the same cycle SHALL replace the stage contents with no lost cycle.
REQ-026 Parameter values outside the stated ranges SHALL cause an elaboration error.

Reset
REQ-027 While resetn=0 at a clock edge, every v_k SHALL clear, and m_tvalid, m_tlast, m_tdata and m_tuser SHALL be 0.
REQ-028 While resetn=0, s_tready SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no partial beat appears afterwards.
REQ-030 s_tready SHALL be 1 in the first cycle after resetn returns to 1.
REQ-031 Data registers other than the outputs need no reset.

Verification
REQ-032 Encrypt, MIX_COLUMNS_EN=1, s_tdata=0, round_key=0 -> m_tdata = all bytes 0x63, 4 cycles later; with round_key all 0xFF -> all bytes 0x9c.
REQ-033 DECRYPT=1, s_tdata=0, round_key=0 -> m_tdata = all bytes 0x52; with MIX_COLUMNS_EN=0 -> also all bytes 0x52.
REQ-034 FIPS-197 App. B round 1, each string byte n placed at [8n+:8]: input 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605 -> output a49c7ff2689f352b6b5bea43026a5049.
REQ-035 Stream of 16 beats with distinct keys/tuser, last beat tlast=1, m_tready random 50% -> scoreboard matches in order, tlast on beat 16 only, no drop, and m_t* stable while stalled.
REQ-036 m_tready=0 for 10 cycles with continuous s_tvalid -> exactly 4 beats accepted, then s_tready=0; release -> 1 beat/cycle resumes.
REQ-037 resetn pulsed low for 1 cycle with 3 beats in flight -> m_tvalid=0 next cycle, none of the 3 beats ever emerge, and s_tready=1 after release.

Source files
------------

// File: rtl/aes_round_pipe.sv
// One AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) as a 4-stage
// elastic AXI-Stream pipeline; ready ripples back combinationally from m_tready.
module aes_round_pipe #(
   parameter int DECRYPT        = 0,
   parameter int MIX_COLUMNS_EN = 1,
   parameter int USER_W         = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [127:0]      s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   input  logic [USER_W-1:0] s_tuser,
   input  logic [127:0]      round_key,
   output logic [127:0]      m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [USER_W-1:0] m_tuser
);

   if (DECRYPT != 0 && DECRYPT != 1) begin : g_bad_decrypt
      $error("aes_round_pipe: DECRYPT must be 0 or 1");
   end
   if (MIX_COLUMNS_EN != 0 && MIX_COLUMNS_EN != 1) begin : g_bad_mix
      $error("aes_round_pipe: MIX_COLUMNS_EN must be 0 or 1");
   end
   if (USER_W < 1 || USER_W > 64) begin : g_bad_user
      $error("aes_round_pipe: USER_W must be in 1..64");
   end

   localparam bit DEC = (DECRYPT != 0);
   localparam bit MIX = (MIX_COLUMNS_EN != 0);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x, input logic dec);
      logic [7:0] y, z;
      if (dec) begin
         z = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
         return ginv(z);
      end
      y = ginv(x);
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic dec);
      logic [127:0] o;
      for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8], dec);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic dec);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((dec ? (c - r + 4) : (c + r)) % 4) + r) +: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic dec);
      logic [127:0] o;
      logic [7:0]   a [4];
      logic [7:0]   m [4];
      m = dec ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[8*(4*c+j) +: 8];
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = gmul(m[0], a[r]) ^ gmul(m[1], a[(r+1)%4]) ^
                                gmul(m[2], a[(r+2)%4]) ^ gmul(m[3], a[(r+3)%4]);
      end
      return o;
   endfunction

   logic [4:1]        vld_q;
   logic              ld1, ld2, ld3, ld4;
   logic [127:0]      dat_q  [1:3];
   logic [127:0]      key_q  [1:3];
   logic [3:1]        last_q;
   logic [USER_W-1:0] user_q [1:3];
   logic [127:0]      dat_d  [1:4];
   logic [127:0]      out_dat_q;
   logic              out_last_q;
   logic [USER_W-1:0] out_user_q;

   // A stage loads when empty or when its contents move on this cycle.
   assign ld4 = !vld_q[4] || m_tready;
   assign ld3 = !vld_q[3] || ld4;
   assign ld2 = !vld_q[2] || ld3;
   assign ld1 = !vld_q[1] || ld2;

   assign s_tready = resetn && ld1;
   assign m_tvalid = vld_q[4];
   assign m_tdata  = out_dat_q;
   assign m_tlast  = out_last_q;
   assign m_tuser  = out_user_q;

   always_comb begin
      dat_d[1] = sub_bytes(s_tdata, DEC);
      dat_d[2] = shift_rows(dat_q[1], DEC);
      dat_d[3] = MIX ? mix_cols(dat_q[2], DEC) : dat_q[2];
      dat_d[4] = dat_q[3] ^ key_q[3];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_q <= '0;
      end else begin
         if (ld1) vld_q[1] <= s_tvalid;
         if (ld2) vld_q[2] <= vld_q[1];
         if (ld3) vld_q[3] <= vld_q[2];
         if (ld4) vld_q[4] <= vld_q[3];
      end
   end

   // Interior payload needs no reset; only the valid flags qualify it.
   always_ff @(posedge clk) begin
      if (ld1) begin
         dat_q[1]  <= dat_d[1];
         key_q[1]  <= round_key;
         last_q[1] <= s_tlast;
         user_q[1] <= s_tuser;
      end
      if (ld2) begin
         dat_q[2]  <= dat_d[2];
         key_q[2]  <= key_q[1];
         last_q[2] <= last_q[1];
         user_q[2] <= user_q[1];
      end
      if (ld3) begin
         dat_q[3]  <= dat_d[3];
         key_q[3]  <= key_q[2];
         last_q[3] <= last_q[2];
         user_q[3] <= user_q[2];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_dat_q  <= '0;
         out_last_q <= 1'b0;
         out_user_q <= '0;
      end else if (ld4) begin
         out_dat_q  <= dat_d[4];
         out_last_q <= last_q[3];
         out_user_q <= user_q[3];
      end
   end

endmodule

// File: tb/tb_aes_round_pipe.sv
// Scoreboard bench for aes_round_pipe: known-answer and random beats checked
// against a table-driven round model under random backpressure and resets.
`timescale 1ns/1ps
module tb_aes_round_pipe;
   localparam int UW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic [127:0]  s_tdata, round_key, m_tdata;
   logic          s_tvalid, s_tready, s_tlast, m_tvalid, m_tlast;
   logic          m_tready = 1'b1;
   logic [UW-1:0] s_tuser, m_tuser;

   logic [127:0]  d_data, d_key, dm_data, dn_data;
   logic          d_valid, dm_rdy, dn_rdy, dm_vld, dn_vld, dm_last, dn_last;
   logic [UW-1:0] dm_user, dn_user;

   aes_round_pipe #(.DECRYPT(0), .MIX_COLUMNS_EN(1), .USER_W(UW)) dut (
      .clk(clk), .resetn(resetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .s_tuser(s_tuser), .round_key(round_key),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tuser(m_tuser));

   aes_round_pipe #(.DECRYPT(1), .MIX_COLUMNS_EN(1), .USER_W(UW)) dut_dm (
      .clk(clk), .resetn(resetn),
      .s_tdata(d_data), .s_tvalid(d_valid), .s_tready(dm_rdy), .s_tlast(1'b0),
      .s_tuser(8'h00), .round_key(d_key),
      .m_tdata(dm_data), .m_tvalid(dm_vld), .m_tready(1'b1), .m_tlast(dm_last),
      .m_tuser(dm_user));

   aes_round_pipe #(.DECRYPT(1), .MIX_COLUMNS_EN(0), .USER_W(UW)) dut_dn (
      .clk(clk), .resetn(resetn),
      .s_tdata(d_data), .s_tvalid(d_valid), .s_tready(dn_rdy), .s_tlast(1'b0),
      .s_tuser(8'h00), .round_key(d_key),
      .m_tdata(dn_data), .m_tvalid(dn_vld), .m_tready(1'b1), .m_tlast(dn_last),
      .m_tuser(dn_user));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sb_t  [256];
   logic [7:0] isb_t [256];

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box from first principles: brute-force inverse, then the affine map
   function automatic void build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sb_t[x]  = s;
         isb_t[s] = 8'(x);
      end
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] in, input logic [127:0] key,
                                              input bit dec, input bit mix);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   m [4];
      logic [127:0] o;
      m = dec ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = dec ? isb_t[in[8*(4*c+r) +: 8]] : sb_t[in[8*(4*c+r) +: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = dec ? s[r][(c - r + 4) % 4] : s[r][(c + r) % 4];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (mix) begin
               s[r][c] = 8'h00;
               for (int j = 0; j < 4; j++) s[r][c] ^= gm(m[(j - r + 4) % 4], t[j][c]);
            end else s[r][c] = t[r][c];
            o[8*(4*c+r) +: 8] = s[r][c] ^ key[8*(4*c+r) +: 8];
         end
      return o;
   endfunction

   function automatic logic [127:0] bsw(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
      return y;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      logic [127:0]  dat;
      logic          last;
      logic [UW-1:0] user;
      int            acc;
      bit            lat;
   } exp_t;
   exp_t sb[$];

   int            cyc = 0;
   int            mode = 0;   // 0: m_tready=1, 1: random, 2: m_tready=0
   bit            kat_on = 0, lat_on = 0, stall_p = 0;
   logic [127:0]  kat_exp, p_dat;
   logic          p_last;
   logic [UW-1:0] p_user;
   int            acc_cnt = 0;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (mode)
         0:       m_tready = 1'b1;
         1:       m_tready = 1'($urandom_range(0, 1));
         default: m_tready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      if (!resetn) stall_p = 0;
      else begin
         if (stall_p) begin
            chk("hold_valid", 128'(m_tvalid), 128'd1);
            chk("hold_data", m_tdata, p_dat);
            chk("hold_side", 128'({m_tlast, m_tuser}), 128'({p_last, p_user}));
         end
         if (s_tvalid && s_tready) begin
            e.dat  = kat_on ? kat_exp : ref_round(s_tdata, round_key, 0, 1);
            e.last = s_tlast;
            e.user = s_tuser;
            e.acc  = cyc;
            e.lat  = lat_on && (sb.size() == 0);
            sb.push_back(e);
            acc_cnt++;
         end
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got data %h, expected no beat", m_tdata);
            end else begin
               e = sb.pop_front();
               chk("out_data", m_tdata, e.dat);
               chk("out_last_user", 128'({m_tlast, m_tuser}), 128'({e.last, e.user}));
               if (e.lat) chk("latency", 128'(cyc - e.acc), 128'd4);
            end
         end
         stall_p = m_tvalid && !m_tready;
         p_dat   = m_tdata;
         p_last  = m_tlast;
         p_user  = m_tuser;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l,
                       input logic [UW-1:0] u);
      int n = 0;
      s_tdata = d; round_key = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         if (++n > 500) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: s_tready 0 for 500 cycles, expected 1");
            break;
         end
      end
      @(posedge clk); #1 s_tvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin @(posedge clk); n++; end
      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic kat(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e);
      kat_exp = e;
      send(d, k, 1'b1, 8'ha5);
      wait_drain();
   endtask

   task automatic dec_beat(input logic [127:0] d, input logic [127:0] k,
                           output logic [127:0] om, output logic [127:0] on);
      d_data = d; d_key = k; d_valid = 1'b1;
      @(negedge clk);
      chk("dec_ready", 128'({dm_rdy, dn_rdy}), 128'b11);
      @(posedge clk); #1 d_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("dec_valid", 128'({dm_vld, dn_vld}), 128'b11);
      om = dm_data;
      on = dn_data;
   endtask

   task automatic set_mode(input int md);
      @(negedge clk); #1 mode = md;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [127:0] om, on, d, k;
      build_tables();
      resetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; round_key = '0; s_tlast = 1'b0;
      s_tuser = '0; d_valid = 1'b0; d_data = '0; d_key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
      chk("rst_s_tready", 128'(s_tready), 128'd0);
      chk("rst_m_tdata", m_tdata, 128'd0);
      chk("rst_last_user", 128'({m_tlast, m_tuser}), 128'd0);
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_s_tready", 128'(s_tready), 128'd1);
      @(posedge clk); #1;

      // known answers with latency checked on an empty pipe
      lat_on = 1; kat_on = 1;
      kat('0, '0, {16{8'h63}});
      kat('0, {16{8'hff}}, {16{8'h9c}});
      kat(bsw(128'h193de3bea0f4e22b9ac68d2ae9f84808), bsw(128'ha0fafe1788542cb123a339392a6c7605),
          bsw(128'ha49c7ff2689f352b6b5bea43026a5049));
      kat_on = 0;
      for (int i = 0; i < 3; i++) begin
         send(rnd128(), rnd128(), 1'b0, 8'(i));
         wait_drain();
      end
      lat_on = 0;

      // 16-beat frame under random backpressure, then a longer random run
      set_mode(1);
      for (int i = 0; i < 16; i++) begin
         send(rnd128(), {rnd128()} ^ 128'(i), i == 15, 8'(8'h10 + i));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_drain();
      for (int i = 0; i < 24; i++) begin
         send(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 8'($urandom));
         repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      wait_drain();

      // full stall: exactly four beats fit, then full rate on release
      set_mode(2);
      acc_cnt = 0;
      s_tdata = rnd128(); round_key = rnd128(); s_tlast = 1'b0; s_tuser = 8'h3c;
      s_tvalid = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("stall_accepted", 128'(acc_cnt), 128'd4);
      chk("stall_s_tready", 128'(s_tready), 128'd0);
      #1 mode = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("full_rate", 128'({m_tvalid, s_tready}), 128'b11);
      end
      @(posedge clk); #1 s_tvalid = 1'b0;
      wait_drain();

      // reset with three beats in flight
      for (int i = 0; i < 3; i++) send(rnd128(), rnd128(), 1'b0, 8'(8'h70 + i));
      resetn = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_s_tready", 128'(s_tready), 128'd0);
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      chk("mid_rst_m_tvalid", 128'(m_tvalid), 128'd0);
      chk("mid_rst_m_tdata", m_tdata, 128'd0);
      chk("mid_rst_s_tready_after", 128'(s_tready), 128'd1);
      repeat (10) @(posedge clk);
      #1;
      send(rnd128(), rnd128(), 1'b1, 8'h99);
      wait_drain();

      // decrypt instances, with and without InvMixColumns
      dec_beat('0, '0, om, on);
      chk("dec_mix_zero", om, {16{8'h52}});
      chk("dec_nomix_zero", on, {16{8'h52}});
      for (int i = 0; i < 3; i++) begin
         d = rnd128(); k = rnd128();
         dec_beat(d, k, om, on);
         chk("dec_mix_rand", om, ref_round(d, k, 1, 1));
         chk("dec_nomix_rand", on, ref_round(d, k, 1, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500us, expected to finish");
      $fatal(1, "watchdog");
   end

endmodule
